// File: rtl/rv_decode_pkg.sv
// Shared RISC-V decode constants: base opcodes and immediate-type encoding.
// Used by the immediate decode stage and the control decoder.
package rv_decode_pkg;

   // Major opcodes, instr[6:0]
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcSystem = 7'b1110011;

   // Immediate format tag carried alongside the decoded immediate; 7 is unused
   typedef enum logic [2:0] {
      ImmNone = 3'd0,
      ImmI    = 3'd1,
      ImmS    = 3'd2,
      ImmB    = 3'd3,
      ImmU    = 3'd4,
      ImmJ    = 3'd5,
      ImmZ    = 3'd6
   } imm_type_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: classifies the instruction format from
// the opcode and builds the XLEN-wide immediate. Unknown opcodes are flagged
// illegal but produce a NONE/zero immediate so the entry can still flow.
module imm_extract
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter bit          CSR_ZIMM_EN = 1'b1
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_type_e       imm_type,
   output logic            illegal
);

   logic [6:0] opcode;
   logic       sign;

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_z;

   assign opcode = instr[6:0];
   assign sign   = instr[31];

   assign imm_i = {{(XLEN-11){sign}}, instr[30:20]};
   assign imm_s = {{(XLEN-11){sign}}, instr[30:25], instr[11:7]};
   assign imm_b = {{(XLEN-12){sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){sign}}, instr[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_z = {{(XLEN-5){1'b0}}, instr[19:15]};

   // Format classification from the opcode
   always_comb begin
      imm_type = ImmNone;
      illegal  = 1'b0;
      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         unique case (opcode)
            OpcLoad, OpcOpImm, OpcJalr: imm_type = ImmI;
            OpcStore:                   imm_type = ImmS;
            OpcBranch:                  imm_type = ImmB;
            OpcLui, OpcAuipc:           imm_type = ImmU;
            OpcJal:                     imm_type = ImmJ;
            // funct3[2] selects the CSR-immediate variants (csrrwi/csrrsi/csrrci)
            OpcSystem:                  imm_type = (CSR_ZIMM_EN && instr[14]) ? ImmZ : ImmI;
            OpcOp:                      imm_type = ImmNone;
            default:                    illegal  = 1'b1;
         endcase
      end
   end

   // Immediate select by format
   always_comb begin
      imm = '0;
      unique case (imm_type)
         ImmI:    imm = imm_i;
         ImmS:    imm = imm_s;
         ImmB:    imm = imm_b;
         ImmU:    imm = imm_u;
         ImmJ:    imm = imm_j;
         ImmZ:    imm = imm_z;
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: decodes the immediate ahead of storage and
// holds results in a 2-entry skid buffer (OUT + SKID) so in_ready can be a
// plain register with no combinational path from out_ready.
module imm_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter bit          CSR_ZIMM_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_imm_type,
   output logic            out_illegal
);

   // Packed entry: {instr, pc, imm, imm_type, illegal}
   localparam int unsigned EntryW = 32 + 2 * XLEN + 3 + 1;

   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StFull
   } state_e;

   state_e state_q, state_d;
   logic   in_ready_q, in_ready_d;

   logic [EntryW-1:0] in_entry;
   logic [EntryW-1:0] out_q, out_d;
   logic [EntryW-1:0] skid_q, skid_d;

   logic [XLEN-1:0] dec_imm;
   imm_type_e       dec_type;
   logic            dec_illegal;

   logic accept;
   logic retire;

   imm_extract #(
      .XLEN        (XLEN),
      .CSR_ZIMM_EN (CSR_ZIMM_EN)
   ) u_imm_extract (
      .instr    (in_instr),
      .imm      (dec_imm),
      .imm_type (dec_type),
      .illegal  (dec_illegal)
   );

   assign in_entry = {in_instr, in_pc, dec_imm, dec_type, dec_illegal};

   assign out_valid = (state_q != StEmpty);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid & in_ready_q;
   assign retire    = out_valid & out_ready;

   assign {out_instr, out_pc, out_imm, out_imm_type, out_illegal} = out_q;

   // Skid-buffer next state and data movement
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               out_d   = in_entry;
               state_d = StOne;
            end
         end
         StOne: begin
            if (accept && retire) begin
               out_d = in_entry;
            end else if (accept) begin
               skid_d  = in_entry;
               state_d = StFull;
            end else if (retire) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            // in_ready is low here, so only a retire can move things
            if (retire) begin
               out_d   = skid_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
      // A coincident retire is already complete downstream; incoming is dropped
      if (flush) begin
         state_d = StEmpty;
      end
      in_ready_d = (state_d != StFull);
   end

   // State and storage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b0;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
      end
   end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath and immediate width; only 32 and 64 are legal.
REQ-002 The block SHALL have parameter CSR_ZIMM_EN, default 1; when 1, CSR-immediate forms yield zero-extended zimm.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush  input  1  discard all held and incoming entries.
REQ-006 The block SHALL have ports in_valid  input  1, in_ready  output  1, in_instr  input  32, in_pc  input  XLEN: upstream handshake, instruction word, instruction PC.
REQ-007 The block SHALL have ports out_valid  output  1 and out_ready  input  1: downstream handshake.
REQ-008 The block SHALL have ports out_instr  output  32, out_pc  output  XLEN, out_imm  output  XLEN, out_imm_type  output  3, out_illegal  output  1.

Function
REQ-009 Transfer SHALL occur on in_valid&in_ready (accept) and on out_valid&out_ready (retire); latency accept-to-out_valid SHALL be exactly 1 cycle when the block is empty.
REQ-010 Storage SHALL be a 2-entry skid buffer: output register (OUT) plus skid register (SKID); states EMPTY, ONE (OUT valid), FULL (OUT+SKID valid).
REQ-011 in_ready SHALL be a registered signal equal to !(state==FULL); no combinational path from out_ready to in_ready.
REQ-012 Transitions: EMPTY+accept->ONE; ONE+accept+retire->ONE (OUT reloaded); ONE+accept+!retire->FULL (entry to SKID); ONE+retire+!accept->EMPTY; FULL+retire->ONE (SKID moves to OUT); all others hold.
REQ-013 Order SHALL be preserved: SKID entry always retires after the OUT entry.
REQ-014 Outputs SHALL remain stable while out_valid&!out_ready.
REQ-015 Immediate decode SHALL be performed before storage and SHALL use opcode in_instr[6:0]: LOAD/OP-IMM/JALR -> I; STORE -> S; BRANCH -> B; LUI/AUIPC -> U; JAL -> J; SYSTEM -> I, except when CSR_ZIMM_EN=1 and funct3[2]=1 -> Z.
REQ-016 I/S/B/J immediates SHALL be sign-extended from instruction bit 31 to XLEN; U SHALL be {instr[31:12],12'b0} sign-extended from bit 31 to XLEN; Z SHALL be instr[19:15] zero-extended to XLEN.
REQ-017 out_imm_type encoding SHALL be NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6; value 7 unused.
REQ-018 OP (0110011) SHALL give type NONE, imm 0, illegal 0.
REQ-019 Any other opcode, or instr[1:0]!=2'b11, SHALL give type NONE, imm 0, out_illegal=1; the entry still flows normally.
REQ-020 flush SHALL empty both registers at the next edge (state EMPTY, out_valid=0 next cycle), SHALL discard an entry accepted in the same cycle, and SHALL set in_ready=1 next cycle.
REQ-021 A retire coincident with flush SHALL count as completed downstream; no replay.

Reset
REQ-022 On rst_n low, asynchronously: state EMPTY, out_valid=0, in_ready=0.
REQ-023 While in reset, out_instr, out_pc, out_imm SHALL be 0, out_imm_type=NONE, out_illegal=0.
REQ-024 in_ready SHALL rise at the first clock edge after rst_n deasserts; reset mid-operation SHALL drop all held entries.

Structure
REQ-025 Opcode constants and imm-type encoding SHALL live in the shared package rv_decode_pkg, reused by the control decoder.
REQ-026 Combinational extraction SHALL be a sub-module imm_extract (instr in; imm, type, illegal out; XLEN parameter); imm_decode_stage SHALL own only the skid buffer and handshake.

Verification
REQ-027 XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, type=1, illegal=0.
REQ-028 in_instr=0x0080006F (jal x0,8) then 0xFE000EE3 (beq x0,x0,-4) back-to-back -> out_imm 0x00000008 type 5, then 0xFFFFFFFC type 3, in order.
REQ-029 XLEN=64, in_instr=0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000, type 4; csrrwi with rs1=31 -> out_imm=0x1F, type 6.
REQ-030 out_ready=0, push 3 entries -> 2 accepted, in_ready=0 after second; raise out_ready -> entries retire in order, in_ready=1 one cycle after first retire.
REQ-031 State FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, accepted entry never appears.
REQ-032 in_instr=0x00000013 with bits[1:0] forced 2'b00 -> out_illegal=1, type 0, imm 0; rst_n pulsed low in FULL -> out_valid=0 immediately.
